banked_mem_ctrl: RTL and testbench
==================================

BANKED_MEM_CTRL -- requirements
Module: banked_mem_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- IMEM_WORDS, 64, instruction-region depth in 32-bit words.
- DMEM_WORDS, 128, data-region depth in 32-bit words.
- IMEM_BASE, 32'h0001_0000, instruction-region base; region hit when addr[31:16]==IMEM_BASE[31:16].
- DMEM_BASE, 32'h8000_0000, data-region base; region hit when addr[31:16]==DMEM_BASE[31:16].
- IMEM_WRITABLE, 0, 1 = stores to the instruction region permitted.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, synchronous, active-high reset.
- req_valid, in, 1, request present.
- req_ready, out, 1, request accepted this cycle when high with req_valid.
- req_we, in, 1, 1 = store, 0 = load.
- req_size, in, 2, 0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned, in, 1, load zero-extends when 1, sign-extends when 0.
- req_addr, in, 32, byte address.
- req_wdata, in, 32, store data, right-aligned.
- rsp_valid, out, 1, response present.
- rsp_ready, in, 1, response consumed when high with rsp_valid.
- rsp_rdata, out, 32, load result, extended; 0 for stores and errors.
- rsp_err, out, 1, access fault for this response.

Function
REQ-003 Each region SHALL be stored as four 8-bit lane arrays (lane k = bits 8k+7:8k); word index = (addr - base) >> 2.
REQ-004 The FSM SHALL have two states: IDLE (no response held) and RESP (rsp_valid=1).
REQ-005 req_ready SHALL equal (state==IDLE) || (rsp_ready==1), combinationally.
REQ-006 An accepted request SHALL produce its response exactly one cycle later (state RESP, rsp_valid=1).
REQ-007 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1.
REQ-008 If rsp_ready=1 and a new request is accepted in the same cycle, the FSM SHALL stay in RESP with the new response (back-to-back, one transaction per cycle).
REQ-009 If rsp_ready=1 and no request is accepted, the FSM SHALL go to IDLE and clear rsp_valid.
REQ-010 A request SHALL fault (rsp_err=1, no array write, rsp_rdata=0) on any of these: no region hit; word index >= region depth; req_size==3; half access with addr[0]=1; word access with addr[1:0]!=0; store to the instruction region with IMEM_WRITABLE=0.
REQ-011 A non-faulting store SHALL write only the addressed lanes on the accept edge:
- byte: lane addr[1:0] <- wdata[7:0].
- half: lanes {addr[1],0} and {addr[1],1} <- wdata[15:0].
- word: all lanes <- wdata.
REQ-012 A non-faulting load SHALL read the addressed word, shift the addressed byte/half to bit 0, then zero- or sign-extend it to 32 bits per req_unsigned; word loads ignore req_unsigned.
REQ-013 A load accepted the cycle after a store to the same word SHALL return the post-store data.
REQ-014 Requests with req_valid=0 SHALL NOT modify the arrays or the FSM state, apart from the response drain in REQ-009.

Reset
REQ-015 While rst=1: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1, and no array write occurs even if req_valid=1.
REQ-016 Assertion of rst while in RESP SHALL discard the pending response.
REQ-017 Array contents SHALL NOT be cleared by reset.

Verification
REQ-018 Store word 32'h1171_9195 at 0x8000_0000, then load word -> rsp_rdata=32'h1171_9195, rsp_err=0, rsp_valid one cycle after each accept.
REQ-019 Store byte 8'h95 at 0x8000_0005, then load byte signed at 0x8000_0005 -> 32'hFFFF_FF95; load byte unsigned at the same address -> 32'h0000_0095; the other lanes of that word are unchanged.
REQ-020 Fault cases:
- load half at 0x8000_0003 -> rsp_err=1, rsp_rdata=0.
- store at 0x0001_0000 with IMEM_WRITABLE=0 -> rsp_err=1, memory unchanged.
- load at 0x8000_0200 (index 128) -> rsp_err=1.
REQ-021 Backpressure: hold rsp_ready=0 for 3 cycles with a load response pending -> response stable and req_ready=0 for those 3 cycles; then rsp_ready=1 with a new req_valid=1 -> the new request is accepted the same cycle and its response appears the next cycle.
REQ-022 Back-to-back throughput: issue 4 consecutive word loads with rsp_ready tied to 1 -> 4 responses on 4 consecutive cycles, in request order.
REQ-023 Reset mid-response: rst=1 while rsp_valid=1 -> next cycle rsp_valid=0, rsp_rdata=0, and previously stored memory data is still readable after reset.

Source files
------------

// File: rtl/banked_mem_ctrl.sv
// banked_mem_ctrl: two-region (instruction/data) byte-lane memory behind a
// valid/ready request channel with a single registered response slot.
// Loads and stores are decoded, checked for faults and executed on the accept
// edge; the response appears one cycle later and is held until consumed.
module banked_mem_ctrl #(
  parameter int          IMEM_WORDS    = 64,
  parameter int          DMEM_WORDS    = 128,
  parameter logic [31:0] IMEM_BASE     = 32'h0001_0000,
  parameter logic [31:0] DMEM_BASE     = 32'h8000_0000,
  parameter bit          IMEM_WRITABLE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IAW = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
  localparam int DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t      state_r;
  logic        hit_i_s;
  logic        hit_d_s;
  logic [31:0] idx_i_s;
  logic [31:0] idx_d_s;
  logic        misalign_s;
  logic        fault_s;
  logic [3:0]  lane_s;
  logic [31:0] wdata_s;
  logic [31:0] iword_s;
  logic [31:0] dword_s;
  logic [31:0] load_s;
  logic [31:0] rdata_next_s;
  logic        accept_s;
  logic [3:0]  we_i_s;
  logic [3:0]  we_d_s;

  // Right-aligned load data extended to 32 bits; word loads pass through.
  function automatic logic [31:0] extend_load(input logic [31:0] sh,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] res;
    case (size)
      2'd0:    res = uns ? {24'h00_0000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    res = uns ? {16'h0000, sh[15:0]}    : {{16{sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Reset forces ready so nothing is held off while the slot is being cleared.
  assign req_ready = rst || (state_r == IDLE) || rsp_ready;
  assign accept_s  = req_valid && req_ready;

  // Address decode, fault detection and store lane/data steering.
  always_comb begin
    hit_i_s = (req_addr[31:16] == IMEM_BASE[31:16]);
    hit_d_s = !hit_i_s && (req_addr[31:16] == DMEM_BASE[31:16]);
    idx_i_s = (req_addr - IMEM_BASE) >> 2'd2;
    idx_d_s = (req_addr - DMEM_BASE) >> 2'd2;
    case (req_size)
      2'd0: begin
        misalign_s = 1'b0;
        lane_s     = 4'b0001 << req_addr[1:0];
        wdata_s    = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        misalign_s = req_addr[0];
        lane_s     = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_s    = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        misalign_s = |req_addr[1:0];
        lane_s     = 4'b1111;
        wdata_s    = req_wdata;
      end
      default: begin
        misalign_s = 1'b1;
        lane_s     = 4'b0000;
        wdata_s    = 32'h0000_0000;
      end
    endcase
    fault_s = misalign_s
           || (!hit_i_s && !hit_d_s)
           || (hit_i_s && (idx_i_s >= 32'(IMEM_WORDS)))
           || (hit_d_s && (idx_d_s >= 32'(DMEM_WORDS)))
           || (hit_i_s && req_we && !IMEM_WRITABLE);
    if (accept_s && !rst && !fault_s && req_we) begin
      we_i_s = hit_i_s ? lane_s : 4'b0000;
      we_d_s = hit_d_s ? lane_s : 4'b0000;
    end else begin
      we_i_s = 4'b0000;
      we_d_s = 4'b0000;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] imem_r [IMEM_WORDS];
    logic [7:0] dmem_r [DMEM_WORDS];

    // Per-lane array write on the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
      if (we_i_s[k]) begin
        imem_r[idx_i_s[IAW-1:0]] <= wdata_s[8*k +: 8];
      end
      if (we_d_s[k]) begin
        dmem_r[idx_d_s[DAW-1:0]] <= wdata_s[8*k +: 8];
      end
    end

    assign iword_s[8*k +: 8] = imem_r[idx_i_s[IAW-1:0]];
    assign dword_s[8*k +: 8] = dmem_r[idx_d_s[DAW-1:0]];
  end

  // Load data path: select region word, align the addressed lane, extend.
  always_comb begin
    load_s = extend_load((hit_i_s ? iword_s : dword_s) >> {req_addr[1:0], 3'b000},
                         req_size, req_unsigned);
    if (fault_s || req_we) begin
      rdata_next_s = 32'h0000_0000;
    end else begin
      rdata_next_s = load_s;
    end
  end

  // Response slot FSM: capture on accept, hold under backpressure, drain when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_next_s;
            rsp_err   <= fault_s;
          end else begin
            state_r   <= IDLE;
          end
        end
        RESP: begin
          if (rsp_ready && accept_s) begin
            state_r   <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata_next_s;
            rsp_err   <= fault_s;
          end else if (rsp_ready) begin
            state_r   <= IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0000_0000;
            rsp_err   <= 1'b0;
          end else begin
            state_r   <= RESP;
          end
        end
        default: begin
          state_r   <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= 32'h0000_0000;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Testbench for banked_mem_ctrl: table of back-to-back requests with
// hand-derived expected results, scoreboard of accepted requests, plus
// sequences for backpressure, throughput and reset during a response.
module tb_banked_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  banked_mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  vec_t  vecs[$];
  exp_t  sb[$];
  exp_t  cur_exp;
  logic  exp_next = 1'b0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic add(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err, input string name);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    cur_exp.rdata = v.exp_rdata;
    cur_exp.err   = v.exp_err;
    cur_exp.name  = v.name;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] exp_rdata, input string name);
    vec_t v;
    v.we = 1'b0; v.size = 2'd2; v.uns = 1'b0; v.addr = addr; v.wdata = 32'h0;
    v.exp_rdata = exp_rdata; v.exp_err = 1'b0; v.name = name;
    apply(v);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: latency check, pop on consumed response, push on accept.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_next = 1'b0;
    end else begin
      if (exp_next) chk("rsp_latency", {31'b0, rsp_valid}, 32'd1);
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
          chk({e.name, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
        end
      end
      exp_next = req_valid && req_ready;
      if (exp_next) sb.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // we size uns addr wdata exp_rdata exp_err
    add(1'b1, 2'd2, 1'b0, 32'h8000_0000, 32'h1171_9195, 32'h0000_0000, 1'b0, "st_w0");
    add(1'b0, 2'd2, 1'b1, 32'h8000_0000, 32'h0,         32'h1171_9195, 1'b0, "ld_w0");
    add(1'b1, 2'd2, 1'b0, 32'h8000_0004, 32'hA1B2_C3D4, 32'h0000_0000, 1'b0, "st_w4");
    add(1'b1, 2'd0, 1'b0, 32'h8000_0005, 32'hDEAD_BE95, 32'h0000_0000, 1'b0, "st_b5");
    add(1'b0, 2'd0, 1'b0, 32'h8000_0005, 32'h0,         32'hFFFF_FF95, 1'b0, "ld_b5_s");
    add(1'b0, 2'd0, 1'b1, 32'h8000_0005, 32'h0,         32'h0000_0095, 1'b0, "ld_b5_u");
    add(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0,         32'hA1B2_95D4, 1'b0, "ld_w4_a");
    add(1'b1, 2'd1, 1'b0, 32'h8000_0006, 32'h1234_8001, 32'h0000_0000, 1'b0, "st_h6");
    add(1'b0, 2'd1, 1'b0, 32'h8000_0006, 32'h0,         32'hFFFF_8001, 1'b0, "ld_h6_s");
    add(1'b0, 2'd1, 1'b1, 32'h8000_0006, 32'h0,         32'h0000_8001, 1'b0, "ld_h6_u");
    add(1'b0, 2'd1, 1'b0, 32'h8000_0004, 32'h0,         32'hFFFF_95D4, 1'b0, "ld_h4_s");
    add(1'b0, 2'd0, 1'b1, 32'h8000_0007, 32'h0,         32'h0000_0080, 1'b0, "ld_b7_u");
    add(1'b0, 2'd0, 1'b0, 32'h8000_0004, 32'h0,         32'hFFFF_FFD4, 1'b0, "ld_b4_s");
    add(1'b0, 2'd1, 1'b0, 32'h8000_0003, 32'h0,         32'h0000_0000, 1'b1, "flt_half_mis");
    add(1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'h5555_5555, 32'h0000_0000, 1'b1, "flt_imem_st");
    add(1'b0, 2'd2, 1'b0, 32'h8000_0200, 32'h0,         32'h0000_0000, 1'b1, "flt_d_oob");
    add(1'b0, 2'd2, 1'b0, 32'h0001_0100, 32'h0,         32'h0000_0000, 1'b1, "flt_i_oob");
    add(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0,         32'h0000_0000, 1'b1, "flt_size3");
    add(1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0,         32'h0000_0000, 1'b1, "flt_word_mis");
    add(1'b0, 2'd2, 1'b0, 32'h4000_0000, 32'h0,         32'h0000_0000, 1'b1, "flt_nohit");
    add(1'b1, 2'd2, 1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, "flt_st_mis");
    add(1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0,         32'h1171_9195, 1'b0, "ld_w0_kept");
    add(1'b1, 2'd2, 1'b0, 32'h8000_01FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, "st_last");
    add(1'b0, 2'd2, 1'b0, 32'h8000_01FC, 32'h0,         32'hCAFE_F00D, 1'b0, "ld_last");
    add(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0,         32'h8001_95D4, 1'b0, "ld_w4_b");

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    cur_exp.rdata = 32'h0; cur_exp.err = 1'b0; cur_exp.name = "none";
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table: one request per cycle, responses consumed immediately.
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      apply(vecs[i]);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    // Backpressure: response A held 3 cycles while request B waits.
    @(posedge clk); #1;
    load(32'h8000_0000, 32'h1171_9195, "bp_a");
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    load(32'h8000_0004, 32'h8001_95D4, "bp_b");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_hold_rdata", rsp_rdata, 32'h1171_9195);
      chk("bp_hold_err", {31'b0, rsp_err}, 32'd0);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    // Throughput: four word loads on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      case (i)
        0:       load(32'h8000_0000, 32'h1171_9195, "tp0");
        1:       load(32'h8000_0004, 32'h8001_95D4, "tp1");
        2:       load(32'h8000_01FC, 32'hCAFE_F00D, "tp2");
        default: load(32'h8000_0000, 32'h1171_9195, "tp3");
      endcase
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    // Reset while a response is pending; a store during reset must not land.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    load(32'h8000_0004, 32'h8001_95D4, "rr_pend");
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_addr = 32'h8000_0000; req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rr_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    chk("rr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rr_rsp_rdata", rsp_rdata, 32'h0);
    chk("rr_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(posedge clk); #1;
    load(32'h8000_0000, 32'h1171_9195, "rr_after0");
    @(posedge clk); #1;
    load(32'h8000_0004, 32'h8001_95D4, "rr_after4");
    @(posedge clk); #1;
    req_valid = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
